sequencer_fsa: RTL and testbench
================================

Name: sequencer_fsa

Overview:
- 24-state sequencer that generates the timing for the Sequencer Unit.
- Produces the one-hot FSA state vector and the twenty derived pulses pA–pT consumed by the instruction decoder.
- Accepts the decoder's early-terminate requests (abort8/10/12/14) and halt.
- Provides run/step control and a completed-instruction counter for the front panel.

Parameters:
- CNT_W, 16: width of instr_count.
- CLK_DIV, 4: clocks per FSA state. Used only when SEQ_CLK_DIV_EN is defined; legal range ≥ 2.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run instructions.
- step  in  1  single-cycle pulse; execute one instruction while stopped.
- halt_req  in  1  from decoder HALT; stop after the current instruction.
- abort8, abort10, abort12, abort14  in  1 each  from decoder; end the instruction early.
- fsa_state  out  24  one-hot FSA state; bit k = S(k+1); all-zero when stopped.
- pulses  out  20  derived pulses; bit 0 = pA … bit 19 = pT.
- running  out  1  1 while an instruction is in progress.
- halted  out  1  1 in HALTED.
- instr_count  out  CNT_W  completed instructions.

Behaviour:
- Reset: asynchronous on reset_n=0.
  - Controller goes to IDLE.
  - fsa_state, pulses, running, halted and instr_count are all 0.
  - Reset mid-instruction aborts it with no count increment.
- Control states:
  - IDLE: run=1 or step=1 → RUN, next state S1. step also sets single_flag.
  - RUN: walk S1→S2→…→S24; S24 → end-of-instruction (EOI).
  - HALTED: halted=1; exit is identical to IDLE.
- Early end:
  - abort8 is sampled only in S8, abort10 only in S10, abort12 only in S12, abort14 only in S14.
  - If the matching abort=1 in that state, the current state is the EOI.
  - An abort outside its state is ignored.
- Halt latching: halt_req=1 in any RUN state sets stop_pend.
- At EOI:
  - instr_count += 1, wrapping modulo 2^CNT_W.
  - If stop_pend, single_flag or run=0: go to HALTED, fsa_state=0, clear stop_pend and single_flag.
  - Otherwise: next state S1, with no gap cycle.
  - A simultaneous abort and halt_req at EOI → HALTED.
  - run dropping mid-instruction never truncates; the instruction completes.
- running=1 exactly while fsa_state≠0.
- Pulses:
  - Registered from the next-state decode, so they are glitch-free and coincide with fsa_state.
  - A pulse is 1 while the state is inside its inclusive range:
    - pA S1–4, pB S2–3, pC S5–6, pD S5, pE S6–7
    - pF S9–10, pG S9, pH S11–12, pI S11, pJ S9–12
    - pK S10–11, pL S13–14, pM S13, pN S15–18, pO S16–17
    - pP S19–22, pQ S19–20, pR S21, pS S23–24, pT S23
  - All pulses are 0 in IDLE/HALTED.
- step is ignored while in RUN.
- Instruction lengths are exactly 8, 10, 12, 14 or 24 states.

Optional Feature:
- Macro: SEQ_CLK_DIV_EN.
- Defined:
  - A mod-CLK_DIV prescaler, cleared by reset, produces adv, which is 1 once every CLK_DIV clocks.
  - FSA transitions, abort sampling and EOI decisions occur only on adv cycles, so each state lasts CLK_DIV clocks.
  - run/step/halt_req are latched on any cycle and acted on at the next adv.
  - The prescaler restarts from 0 on leaving IDLE/HALTED, so S1 lasts the full CLK_DIV clocks.
- Undefined: adv is tied to 1; one state per clock; CLK_DIV is unused.

Test Plan:
1. Reset, run=1, no aborts → fsa_state goes 0x000001…0x800000, then S1 again 24 cycles after first S1. pA high in cycles 1–4, pT in cycle 23. instr_count=1 after the first S24.
2. run=1, abort8=1 during S5 and S8 → S5 abort ignored; after S8 next is S1 (8-state instruction). pF is never asserted.
3. run=1, halt_req pulse in S3, abort12=1 in S12 → after S12: halted=1, fsa_state=0, pulses=0, instr_count incremented by 1.
4. From HALTED, one step pulse with abort10=1 in S10 → exactly 10 states (S1–S10), then halted=1; count +1. A second step in S4 has no effect.
5. reset_n=0 asynchronously mid-S15 → same cycle: fsa_state=0, pulses=0, instr_count=0, running=0. After release with run=1, sequencing restarts at S1.
6. SEQ_CLK_DIV_EN, CLK_DIV=4, abort14 in S14 → each state lasts 4 clocks; instruction totals 56 clocks; pA high for 16 clocks.

Source files
------------

// File: rtl/sequencer_fsa.sv
// 24-state FSA sequencer: one-hot state, derived pulses pA-pT, run/step/halt control.
// Optional SEQ_CLK_DIV_EN stretches each FSA state to CLK_DIV clocks.
module sequencer_fsa #(
    parameter int CNT_W   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             abort8,
    input  logic             abort10,
    input  logic             abort12,
    input  logic             abort14,
    output logic [23:0]      fsa_state,
    output logic [19:0]      pulses,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} ctrl_t;

    localparam logic [4:0] P_LO [20] = '{5'd1, 5'd2, 5'd5, 5'd5, 5'd6, 5'd9, 5'd9, 5'd11, 5'd11, 5'd9,
                                         5'd10, 5'd13, 5'd13, 5'd15, 5'd16, 5'd19, 5'd19, 5'd21, 5'd23, 5'd23};
    localparam logic [4:0] P_HI [20] = '{5'd4, 5'd3, 5'd6, 5'd5, 5'd7, 5'd10, 5'd9, 5'd12, 5'd11, 5'd12,
                                         5'd11, 5'd14, 5'd13, 5'd18, 5'd17, 5'd22, 5'd20, 5'd21, 5'd24, 5'd23};

    ctrl_t      ctrl;
    logic [4:0] idx;        // 0 = stopped, 1..24 = S1..S24
    logic [4:0] nxt_idx;
    logic       stop_pend;
    logic       single_flag;
    logic       adv;
    logic       step_seen;
    logic       start;
    logic       eoi;
    logic       stop_now;

    function automatic logic [23:0] onehot(input logic [4:0] s);
        logic [23:0] v;
        v = '0;
        if (s != 5'd0) v = 24'd1 << (s - 5'd1);
        return v;
    endfunction

    function automatic logic [19:0] decode(input logic [4:0] s);
        logic [19:0] p;
        p = '0;
        for (int unsigned i = 0; i < 20; i++)
            p[i] = (s >= P_LO[i]) && (s <= P_HI[i]);
        return p;
    endfunction

`ifdef SEQ_CLK_DIV_EN
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc;
    logic          step_lat;

    // Free-running mod-CLK_DIV prescaler; leaving IDLE/HALTED happens on the wrap,
    // so S1 always starts with a fresh count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            step_lat <= 1'b0;
        end else begin
            presc    <= adv ? '0 : presc + PW'(1);
            step_lat <= adv ? 1'b0 : (step_lat | (step && (ctrl != RUN)));
        end
    end

    assign adv       = (presc == PW'(CLK_DIV - 1));
    assign step_seen = step | step_lat;
`else
    logic unused_div;
    assign unused_div = (CLK_DIV >= 2);
    assign adv        = 1'b1;
    assign step_seen  = step;
`endif

    always_comb begin
        start    = (ctrl != RUN) && (run || step_seen);
        eoi      = (ctrl == RUN) &&
                   ((idx == 5'd24) ||
                    (idx == 5'd8  && abort8)  ||
                    (idx == 5'd10 && abort10) ||
                    (idx == 5'd12 && abort12) ||
                    (idx == 5'd14 && abort14));
        stop_now = stop_pend || halt_req || single_flag || !run;
        nxt_idx  = idx;
        if (adv) begin
            if (start)
                nxt_idx = 5'd1;
            else if (eoi)
                nxt_idx = stop_now ? 5'd0 : 5'd1;
            else if (ctrl == RUN)
                nxt_idx = idx + 5'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl        <= IDLE;
            idx         <= '0;
            fsa_state   <= '0;
            pulses      <= '0;
            running     <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            stop_pend   <= 1'b0;
            single_flag <= 1'b0;
        end else begin
            idx       <= nxt_idx;
            fsa_state <= onehot(nxt_idx);
            pulses    <= decode(nxt_idx);
            running   <= (nxt_idx != 5'd0);
            if (ctrl == RUN && halt_req)
                stop_pend <= 1'b1;
            if (adv) begin
                if (start) begin
                    ctrl        <= RUN;
                    halted      <= 1'b0;
                    single_flag <= step_seen;
                end else if (eoi) begin
                    instr_count <= instr_count + CNT_W'(1);
                    if (stop_now) begin
                        ctrl        <= HALTED;
                        halted      <= 1'b1;
                        stop_pend   <= 1'b0;
                        single_flag <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sequencer_fsa.sv
// Scoreboard bench for sequencer_fsa: stimulus pushes expected state per clock,
// a negedge monitor pops and compares.
module tb_sequencer_fsa;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run, step, halt_req;
    logic        abort8, abort10, abort12, abort14;
    logic [23:0] fsa_state;
    logic [19:0] pulses;
    logic        running, halted;
    logic [15:0] instr_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [23:0] fsa;
        logic [19:0] p;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    int p_lo[20] = '{1, 2, 5, 5, 6, 9, 9, 11, 11, 9, 10, 13, 13, 15, 16, 19, 19, 21, 23, 23};
    int p_hi[20] = '{4, 3, 6, 5, 7, 10, 9, 12, 11, 12, 11, 14, 13, 18, 17, 22, 20, 21, 24, 23};

    sequencer_fsa #(.CNT_W(16), .CLK_DIV(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .abort8      (abort8),
        .abort10     (abort10),
        .abort12     (abort12),
        .abort14     (abort14),
        .fsa_state   (fsa_state),
        .pulses      (pulses),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input int s, input logic h, input int c, input string tag);
        exp_t e;
        logic [23:0] one;
        one   = 24'd1;
        e.fsa = (s == 0) ? 24'd0 : (one << (s - 1));
        e.p   = '0;
        for (int i = 0; i < 20; i++)
            e.p[i] = (s >= p_lo[i]) && (s <= p_hi[i]);
        e.run = (s != 0);
        e.hlt = h;
        e.cnt = 16'(c);
        e.tag = tag;
        return e;
    endfunction

    task automatic check(input exp_t e);
        tests++;
        if (fsa_state !== e.fsa || pulses !== e.p || running !== e.run ||
            halted !== e.hlt || instr_count !== e.cnt) begin
            fails++;
            $display("FAIL %s: got fsa=%h p=%h run=%b hlt=%b cnt=%0d, expected fsa=%h p=%h run=%b hlt=%b cnt=%0d",
                     e.tag, fsa_state, pulses, running, halted, instr_count,
                     e.fsa, e.p, e.run, e.hlt, e.cnt);
        end
    endtask

    // Drive inputs for the next rising edge, then queue the expected post-edge state.
    task automatic tick(input logic r, input logic st, input logic h, input int ab,
                        input int e_s, input logic e_h, input int e_c, input string tag);
        run      = r;
        step     = st;
        halt_req = h;
        abort8   = (ab == 8);
        abort10  = (ab == 10);
        abort12  = (ab == 12);
        abort14  = (ab == 14);
        @(posedge clock);
        #1;
        exp_q.push_back(mk(e_s, e_h, e_c, tag));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n = 1'b0;
        run = 0; step = 0; halt_req = 0;
        abort8 = 0; abort10 = 0; abort12 = 0; abort14 = 0;
        #3;
        exp_q.push_back(mk(0, 1'b0, 0, "reset"));
        #20;
        reset_n = 1'b1;

`ifdef SEQ_CLK_DIV_EN
        begin : div_test
            bit found;
            found = 0;
            run = 1'b1;
            abort14 = 1'b1;
            for (int i = 0; i < 10 && !found; i++) begin
                @(posedge clock);
                #1;
                if (fsa_state == 24'd1) found = 1;
            end
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL div_start: got fsa=%h, expected S1 within 10 clocks", fsa_state);
            end
            for (int k = 1; k <= 56; k++)
                tick(1, 0, 0, 14, (k < 56) ? (k / 4 + 1) : 1, 1'b0, (k < 56) ? 0 : 1, "div_walk");
        end
`else
        // Full 24-state instruction, free running
        tick(1, 0, 0, 0, 1, 1'b0, 0, "t1_s1");
        for (int s = 2; s <= 24; s++) tick(1, 0, 0, 0, s, 1'b0, 0, "t1_walk");
        tick(1, 0, 0, 0, 1, 1'b0, 1, "t1_wrap");

        // abort8 in S5 ignored, honoured in S8
        for (int s = 2; s <= 8; s++) tick(1, 0, 0, (s == 6) ? 8 : 0, s, 1'b0, 1, "t2_walk");
        tick(1, 0, 0, 8, 1, 1'b0, 2, "t2_abort8");

        // halt_req in S3 latched, abort12 ends instruction into HALTED
        for (int s = 2; s <= 12; s++) tick(1, 0, (s == 4), 0, s, 1'b0, 2, "t3_walk");
        tick(1, 0, 0, 12, 0, 1'b1, 3, "t3_halt");
        tick(0, 0, 0, 0, 0, 1'b1, 3, "t3_stay");

        // single step with abort10, second step in S4 ignored
        tick(0, 1, 0, 0, 1, 1'b0, 3, "t4_s1");
        for (int s = 2; s <= 10; s++) tick(0, (s == 5), 0, 0, s, 1'b0, 3, "t4_walk");
        tick(0, 0, 0, 10, 0, 1'b1, 4, "t4_halt");
        tick(0, 0, 0, 0, 0, 1'b1, 4, "t4_stay");

        // run dropped in S5 still completes the full instruction
        tick(1, 0, 0, 0, 1, 1'b0, 4, "ta_s1");
        for (int s = 2; s <= 24; s++) tick((s <= 5), 0, 0, 0, s, 1'b0, 4, "ta_walk");
        tick(0, 0, 0, 0, 0, 1'b1, 5, "ta_halt");

        // simultaneous halt_req and abort14 at EOI
        tick(1, 0, 0, 0, 1, 1'b0, 5, "tb_s1");
        for (int s = 2; s <= 14; s++) tick(1, 0, 0, 0, s, 1'b0, 5, "tb_walk");
        tick(1, 0, 1, 14, 0, 1'b1, 6, "tb_halt");
        tick(0, 0, 0, 0, 0, 1'b1, 6, "tb_stay");

        // asynchronous reset mid-S15
        tick(1, 0, 0, 0, 1, 1'b0, 6, "t5_s1");
        for (int s = 2; s <= 15; s++) tick(1, 0, 0, 0, s, 1'b0, 6, "t5_walk");
        #5;
        reset_n = 1'b0;
        #1;
        check(mk(0, 1'b0, 0, "t5_async"));
        @(posedge clock);
        #1;
        exp_q.push_back(mk(0, 1'b0, 0, "t5_held"));
        #3;
        reset_n = 1'b1;
        tick(1, 0, 0, 0, 1, 1'b0, 0, "t5_restart");
        tick(1, 0, 0, 0, 2, 1'b0, 0, "t5_s2");
`endif

        repeat (3) @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
